// File: rtl/dual_rail_receiver.sv
// Precharged dual-rail word receiver: checks NULL/VALID alternation,
// captures each VALID word to single-rail and flags protocol faults.
module dual_rail_receiver #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             reset_1,
    input  logic [WIDTH-1:0] D_t,
    input  logic [WIDTH-1:0] D_f,
    input  logic             rx_en,
    input  logic             clear_fault,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [15:0]      word_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_PRE  = 2'd1,
        WAIT_EVAL = 2'd2,
        ERROR     = 2'd3
    } state_t;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_ILL  = 2'b01;
    localparam logic [1:0] CODE_PRE  = 2'b10;
    localparam logic [1:0] CODE_MIX  = 2'b11;

    state_t           state_q, state_d;
    logic             first_q, first_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             fault_q, fault_d;
    logic [1:0]       code_q, code_d;
    logic [15:0]      cnt_q, cnt_d;

    logic is_ill, is_nul, is_vld;

    // Word classification; ILLEGAL wins over everything else.
    assign is_ill = |(D_t & D_f);
    assign is_nul = ~is_ill & ~|(D_t | D_f);
    assign is_vld = ~is_ill & (&(D_t ^ D_f));

    always_comb begin
        state_d = state_q;
        first_d = first_q;
        data_d  = data_q;
        valid_d = 1'b0;
        fault_d = fault_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (rx_en) begin
                    state_d = WAIT_PRE;
                    first_d = 1'b1;
                end
            end
            WAIT_PRE: begin
                if (!rx_en) begin
                    state_d = IDLE;
                end else if (is_ill) begin
                    state_d = ERROR;
                    fault_d = 1'b1;
                    code_d  = CODE_ILL;
                end else if (is_nul) begin
                    state_d = WAIT_EVAL;
                    first_d = 1'b0;
                end else if (is_vld && !first_q) begin
                    state_d = ERROR;
                    fault_d = 1'b1;
                    code_d  = CODE_PRE;
                end
            end
            WAIT_EVAL: begin
                if (!rx_en) begin
                    state_d = IDLE;
                end else if (is_ill) begin
                    state_d = ERROR;
                    fault_d = 1'b1;
                    code_d  = CODE_ILL;
                end else if (is_vld) begin
                    state_d = WAIT_PRE;
                    data_d  = D_t;
                    valid_d = 1'b1;
                    if (cnt_q != 16'hFFFF)
                        cnt_d = cnt_q + 16'd1;
                end else if (!is_nul) begin
                    state_d = ERROR;
                    fault_d = 1'b1;
                    code_d  = CODE_MIX;
                end
            end
            ERROR: begin
                if (clear_fault) begin
                    state_d = IDLE;
                    fault_d = 1'b0;
                    code_d  = CODE_NONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset_1) begin
            state_q <= IDLE;
            first_q <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= CODE_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign word_count = cnt_q;

endmodule

// File: doc/dual_rail_receiver.md
DUAL_RAIL_RECEIVER -- requirements
Module: dual_rail_receiver

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the number of dual-rail data bits.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_1  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port D_t  input  WIDTH  true rail of the incoming precharged dual-rail word.
REQ-005 SHALL have port D_f  input  WIDTH  false rail of the incoming precharged dual-rail word.
REQ-006 SHALL have port rx_en  input  1  receive enable.
REQ-007 SHALL have port clear_fault  input  1  leaves ERROR and returns to IDLE.
REQ-008 SHALL have port data_out  output  WIDTH  last captured single-rail word, taken from D_t.
REQ-009 SHALL have port data_valid  output  1  one-cycle capture strobe.
REQ-010 SHALL have port fault  output  1  sticky fault flag, high only in ERROR.
REQ-011 SHALL have port fault_code  output  2  cause of the fault: 01 illegal 11 code; 10 missing precharge; 11 incomplete word.
REQ-012 SHALL have port word_count  output  16  number of captured words, saturating.

Function
REQ-013 SHALL classify each sampled word combinationally, in priority order: ILLEGAL (any bit t=f=1); NULL (every bit 00); VALID (every bit 01 or 10); MIXED (all others).
REQ-014 SHALL implement states IDLE, WAIT_PRE, WAIT_EVAL and ERROR; all outputs SHALL be registered.
REQ-015 IDLE: rx_en=1 -> WAIT_PRE with the internal flag first set to 1; input words are otherwise ignored.
REQ-016 WAIT_PRE: NULL -> WAIT_EVAL and clears first; VALID with first=1 -> stay (tolerates the transmitter's reset word 0/1); VALID with first=0 -> ERROR, code 10; MIXED -> stay.
REQ-017 WAIT_EVAL: NULL -> stay (consecutive precharge cycles allowed); VALID -> capture, then WAIT_PRE; MIXED -> ERROR, code 11.
REQ-018 ILLEGAL in WAIT_PRE or WAIT_EVAL -> ERROR, code 01; this overrides every other transition.
REQ-019 On capture: data_out<=D_t and data_valid<=1 at the same edge; data_valid SHALL fall at the next edge (exactly one cycle high).
REQ-020 word_count SHALL increment by 1 on each capture and SHALL saturate at 16'hFFFF (no wrap).
REQ-021 data_out SHALL hold its value between captures, including while in ERROR and IDLE.
REQ-022 ERROR: fault=1 and fault_code SHALL hold until clear_fault or reset; clear_fault=1 -> IDLE with fault<=0 and fault_code<=00; input words are ignored.
REQ-023 rx_en=0 in WAIT_PRE or WAIT_EVAL -> IDLE with no fault; a word sampled in that same cycle SHALL NOT be captured or faulted.
REQ-024 Priority within one cycle: reset_1 > clear_fault (ERROR only) > rx_en=0 > ILLEGAL > the other classifications.
REQ-025 fault_code SHALL be 00 whenever fault=0.

Reset
REQ-026 reset_1=1 at a clock edge SHALL force state=IDLE, first=1, data_out=0, data_valid=0, fault=0, fault_code=00, word_count=0, regardless of current state or other inputs, including mid-word.
REQ-027 No output SHALL change asynchronously on reset_1; all reset effects SHALL occur at the CLK edge.

Verification
REQ-028 Scenario: reset, rx_en=1, drive (t,f)=(00,FF) for 2 cycles, then (00,00), then (A5,5A) -> data_valid high for one cycle, data_out=A5, word_count=1, fault=0.
REQ-029 Scenario: after a capture of A5, drive (3C,C3) with no NULL between words -> fault=1, fault_code=10, no capture, word_count unchanged.
REQ-030 Scenario: in WAIT_EVAL, drive (01,01) -> fault_code=01; then a VALID word -> still ERROR; then clear_fault pulse -> IDLE, fault=0, fault_code=00.
REQ-031 Scenario: in WAIT_EVAL, drive (0F,00) (MIXED) -> fault_code=11; in WAIT_PRE the same word SHALL NOT fault.
REQ-032 Scenario: preload word_count to FFFE via 65534 alternating NULL/VALID pairs (or via a forced state), then 3 more captures -> word_count stays FFFF.
REQ-033 Scenario: reset_1 asserted in the cycle a VALID word arrives in WAIT_EVAL -> no data_valid, data_out=0, state IDLE; also rx_en=0 with ILLEGAL in the same cycle -> IDLE, fault=0.
